// File: rtl/tcu_ctrl_reg_arbiter_pkg.sv
// ============================================================================
// Module   : tcu_ctrl_reg_arbiter_pkg
// Brief    : Shared TCU register-file widths and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcu_ctrl_reg_arbiter_pkg;

  localparam int TCU_REG_ADDR_SIZE = 32;
  localparam int TCU_REG_DATA_SIZE = 64;

  typedef enum logic [0:0] {
    ARB_S_IDLE  = 1'b0,
    ARB_S_OWNED = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/tcu_rr_pick.sv
// ============================================================================
// Module   : tcu_rr_pick
// Brief    : Combinational round-robin picker: first set candidate after ptr_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic w_found;
  int   w_j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_j     = 0;
    // k = NUM_REQ wraps back to ptr_i itself, so it is checked last
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = (int'(ptr_i) + k) % NUM_REQ;
      if (!w_found && cand_i[IDX_W'(w_j)]) begin
        w_found                 = 1'b1;
        grant_o[IDX_W'(w_j)]    = 1'b1;
        idx_o                   = IDX_W'(w_j);
      end
    end
    valid_o = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/tcu_ctrl_reg_arbiter.sv
// ============================================================================
// Module   : tcu_ctrl_reg_arbiter
// Brief    : Sequence-holding round-robin arbiter for the TCU register port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcu_ctrl_reg_arbiter
  import tcu_ctrl_reg_arbiter_pkg::*;
#(
  parameter int                 NUM_REQ     = 4,
  parameter logic [NUM_REQ-1:0] HIPRIO_MASK = '0
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [NUM_REQ-1:0]                     req_active_i,
  input  logic [NUM_REQ-1:0]                     req_en_i,
  input  logic [NUM_REQ-1:0]                     req_wr_i,
  input  logic [NUM_REQ*TCU_REG_ADDR_SIZE-1:0]   req_addr_i,
  input  logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                     req_stall_o,
  output logic [NUM_REQ-1:0]                     req_rvalid_o,
  output logic [TCU_REG_DATA_SIZE-1:0]           req_rdata_o,
  output logic                                   reg_en_o,
  output logic                                   reg_wr_o,
  output logic [TCU_REG_ADDR_SIZE-1:0]           reg_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0]           reg_wdata_o,
  input  logic [TCU_REG_DATA_SIZE-1:0]           reg_rdata_i,
  input  logic                                   reg_stall_i,
  output logic [NUM_REQ-1:0]                     arb_err_o
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_aw    = TCU_REG_ADDR_SIZE;
  localparam int c_dw    = TCU_REG_DATA_SIZE;

  arb_state_e           r_state, w_state_nxt;
  logic [c_idx_w-1:0]   r_owner, w_owner_nxt;
  logic [c_idx_w-1:0]   r_last, w_last_nxt;
  logic [NUM_REQ-1:0]   r_owner_oh, w_owner_oh_nxt;
  logic [c_idx_w-1:0]   r_rv_owner;
  logic                 r_rv;
  logic [NUM_REQ-1:0]   r_err;

  logic [NUM_REQ-1:0]   w_hi_cand, w_hi_oh, w_all_oh, w_win_oh;
  logic [c_idx_w-1:0]   w_hi_idx, w_all_idx, w_win_idx;
  logic                 w_hi_vld, w_all_vld;
  logic                 w_owned;
  logic [NUM_REQ-1:0]   w_stall;

  logic [c_aw-1:0]      w_addr_arr  [NUM_REQ];
  logic [c_dw-1:0]      w_wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr_i[gi*c_aw +: c_aw];
      assign w_wdata_arr[gi] = req_wdata_i[gi*c_dw +: c_dw];
    end
  endgenerate

  // Two pickers share the pointer; the masked class wins whenever it has anyone active
  assign w_hi_cand = req_active_i & HIPRIO_MASK;

  tcu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_pick_hi (
    .cand_i  (w_hi_cand),
    .ptr_i   (r_last),
    .grant_o (w_hi_oh),
    .idx_o   (w_hi_idx),
    .valid_o (w_hi_vld)
  );

  tcu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_pick_all (
    .cand_i  (req_active_i),
    .ptr_i   (r_last),
    .grant_o (w_all_oh),
    .idx_o   (w_all_idx),
    .valid_o (w_all_vld)
  );

  assign w_win_oh  = w_hi_vld ? w_hi_oh  : w_all_oh;
  assign w_win_idx = w_hi_vld ? w_hi_idx : w_all_idx;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_owner_oh_nxt = r_owner_oh;
    w_last_nxt     = r_last;
    case (r_state)
      ARB_S_IDLE: begin
        if (w_all_vld) begin
          w_state_nxt    = ARB_S_OWNED;
          w_owner_nxt    = w_win_idx;
          w_owner_oh_nxt = w_win_oh;
          w_last_nxt     = w_win_idx;
        end
      end
      ARB_S_OWNED: begin
        // Owner's active bit is already low here, so the pickers see only the others
        if (!req_active_i[r_owner]) begin
          if (w_all_vld) begin
            w_owner_nxt    = w_win_idx;
            w_owner_oh_nxt = w_win_oh;
            w_last_nxt     = w_win_idx;
          end else begin
            w_state_nxt    = ARB_S_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_S_IDLE;
    endcase
  end

  assign w_owned     = (r_state == ARB_S_OWNED);
  assign w_stall     = {NUM_REQ{reg_stall_i | ~w_owned}} | ~r_owner_oh;
  assign req_stall_o = w_stall;

  assign reg_en_o    = w_owned & req_en_i[r_owner] & ~reg_stall_i;
  assign reg_wr_o    = w_owned & req_wr_i[r_owner];
  assign reg_addr_o  = w_owned ? w_addr_arr[r_owner]  : '0;
  assign reg_wdata_o = w_owned ? w_wdata_arr[r_owner] : '0;
  assign req_rdata_o = reg_rdata_i;
  assign arb_err_o   = r_err;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
      assign req_rvalid_o[gi] = r_rv & (r_rv_owner == c_idx_w'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= ARB_S_IDLE;
      r_owner    <= '0;
      r_owner_oh <= NUM_REQ'(1);
      r_last     <= c_idx_w'(NUM_REQ-1);
      r_rv       <= 1'b0;
      r_rv_owner <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_oh <= w_owner_oh_nxt;
      r_last     <= w_last_nxt;
      // Read tag is captured with the current owner so a release cannot misroute it
      r_rv       <= reg_en_o & ~reg_wr_o;
      r_rv_owner <= r_owner;
      r_err      <= r_err | (req_en_i & w_stall);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcu_ctrl_reg_arbiter.sv
// ============================================================================
// Module   : tb_tcu_ctrl_reg_arbiter
// Brief    : Cycle-table bench for the TCU register-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcu_ctrl_reg_arbiter;
  import tcu_ctrl_reg_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, no high-priority class
  logic         rst = 1'b1;
  logic [3:0]   act = '0, en = '0, wr = '0;
  logic [127:0] addr = '0;
  logic [255:0] wdata = '0;
  logic [3:0]   stall, rvalid, err;
  logic [63:0]  rdata, reg_wdata;
  logic         reg_en, reg_wr, reg_stall = 1'b0;
  logic [31:0]  reg_addr;
  logic [63:0]  reg_rdata = '0;

  tcu_ctrl_reg_arbiter #(.NUM_REQ(4), .HIPRIO_MASK(4'b0000)) dut (
    .clk_i(clk), .reset_i(rst),
    .req_active_i(act), .req_en_i(en), .req_wr_i(wr),
    .req_addr_i(addr), .req_wdata_i(wdata),
    .req_stall_o(stall), .req_rvalid_o(rvalid), .req_rdata_o(rdata),
    .reg_en_o(reg_en), .reg_wr_o(reg_wr), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata),
    .reg_stall_i(reg_stall), .arb_err_o(err)
  );

  // Downstream register file: read data is a function of the address, one cycle later
  always @(posedge clk) if (reg_en && !reg_wr) reg_rdata <= {32'hCAFE0000, reg_addr};

  // Second instance with requester 3 in the high-priority class
  logic         h_rst = 1'b1;
  logic [3:0]   h_act = '0, h_en = '0, h_wr = '0;
  logic [127:0] h_addr = '0;
  logic [255:0] h_wdata = '0;
  logic [3:0]   h_stall, h_rvalid, h_err;
  logic [63:0]  h_rdata, h_reg_wdata;
  logic         h_reg_en, h_reg_wr, h_reg_stall = 1'b0;
  logic [31:0]  h_reg_addr;
  logic [63:0]  h_reg_rdata = '0;

  tcu_ctrl_reg_arbiter #(.NUM_REQ(4), .HIPRIO_MASK(4'b1000)) dut_hp (
    .clk_i(clk), .reset_i(h_rst),
    .req_active_i(h_act), .req_en_i(h_en), .req_wr_i(h_wr),
    .req_addr_i(h_addr), .req_wdata_i(h_wdata),
    .req_stall_o(h_stall), .req_rvalid_o(h_rvalid), .req_rdata_o(h_rdata),
    .reg_en_o(h_reg_en), .reg_wr_o(h_reg_wr), .reg_addr_o(h_reg_addr),
    .reg_wdata_o(h_reg_wdata), .reg_rdata_i(h_reg_rdata),
    .reg_stall_i(h_reg_stall), .arb_err_o(h_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  act;
    logic [3:0]  en;
    logic        wr;
    logic [31:0] addr;
    logic        rs;
    logic [3:0]  e_stall;
    logic [3:0]  e_rv;
    logic        e_en;
    int          own;     // -1: port not owned
    logic [3:0]  e_err;
  } vec_t;

  localparam int NV = 32;
  vec_t tv [NV];

  function automatic vec_t mk(logic r, logic [3:0] a, logic [3:0] e, logic w, logic [31:0] ad,
                              logic s, logic [3:0] est, logic [3:0] erv, logic een, int own,
                              logic [3:0] eerr);
    vec_t v;
    v.rst = r; v.act = a; v.en = e; v.wr = w; v.addr = ad; v.rs = s;
    v.e_stall = est; v.e_rv = erv; v.e_en = een; v.own = own; v.e_err = eerr;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_addr, prev_addr;
    logic [63:0] exp_wdata;
    logic        exp_wr;

    //               rst act   en    wr addr   rs  stall rv    en own err
    tv[0]  = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[1]  = mk(0, 4'h5, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[2]  = mk(0, 4'h5, 4'h1, 1, 32'h10, 0, 4'hE, 4'h0, 1,  0, 4'h0);
    tv[3]  = mk(0, 4'h5, 4'h1, 0, 32'h18, 0, 4'hE, 4'h0, 1,  0, 4'h0);
    tv[4]  = mk(0, 4'h4, 4'h0, 0, 32'h00, 0, 4'hE, 4'h1, 0,  0, 4'h0);
    tv[5]  = mk(0, 4'h4, 4'h4, 0, 32'h20, 0, 4'hB, 4'h0, 1,  2, 4'h0);
    tv[6]  = mk(0, 4'h4, 4'h0, 0, 32'h00, 0, 4'hB, 4'h4, 0,  2, 4'h0);
    tv[7]  = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hB, 4'h0, 0,  2, 4'h0);
    tv[8]  = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[9]  = mk(0, 4'h2, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[10] = mk(0, 4'h2, 4'h2, 0, 32'h40, 0, 4'hD, 4'h0, 1,  1, 4'h0);
    tv[11] = mk(0, 4'h2, 4'h2, 0, 32'h48, 0, 4'hD, 4'h2, 1,  1, 4'h0);
    tv[12] = mk(0, 4'h2, 4'h2, 0, 32'h50, 0, 4'hD, 4'h2, 1,  1, 4'h0);
    tv[13] = mk(0, 4'h2, 4'h0, 0, 32'h00, 0, 4'hD, 4'h2, 0,  1, 4'h0);
    tv[14] = mk(0, 4'h2, 4'h0, 0, 32'h60, 1, 4'hF, 4'h0, 0,  1, 4'h0);
    tv[15] = mk(0, 4'h2, 4'h0, 0, 32'h60, 1, 4'hF, 4'h0, 0,  1, 4'h0);
    tv[16] = mk(0, 4'h2, 4'h0, 0, 32'h60, 1, 4'hF, 4'h0, 0,  1, 4'h0);
    tv[17] = mk(0, 4'h2, 4'h2, 0, 32'h60, 0, 4'hD, 4'h0, 1,  1, 4'h0);
    tv[18] = mk(0, 4'h2, 4'h0, 0, 32'h00, 0, 4'hD, 4'h2, 0,  1, 4'h0);
    tv[19] = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hD, 4'h0, 0,  1, 4'h0);
    tv[20] = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[21] = mk(0, 4'h1, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[22] = mk(0, 4'h1, 4'h5, 0, 32'h70, 0, 4'hE, 4'h0, 1,  0, 4'h0);
    tv[23] = mk(0, 4'h1, 4'h1, 0, 32'h78, 0, 4'hE, 4'h1, 1,  0, 4'h4);
    tv[24] = mk(0, 4'h1, 4'h4, 0, 32'h00, 0, 4'hE, 4'h1, 0,  0, 4'h4);
    tv[25] = mk(0, 4'h1, 4'h0, 0, 32'h00, 0, 4'hE, 4'h0, 0,  0, 4'h4);
    tv[26] = mk(1, 4'h1, 4'h1, 0, 32'h80, 0, 4'hE, 4'h0, 1,  0, 4'h4);
    tv[27] = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[28] = mk(0, 4'h8, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);
    tv[29] = mk(0, 4'h8, 4'h8, 0, 32'h90, 0, 4'h7, 4'h0, 1,  3, 4'h0);
    tv[30] = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'h7, 4'h8, 0,  3, 4'h0);
    tv[31] = mk(0, 4'h0, 4'h0, 0, 32'h00, 0, 4'hF, 4'h0, 0, -1, 4'h0);

    repeat (2) @(posedge clk);
    #1 h_rst = 1'b0;
    prev_addr = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst       = tv[i].rst;
      act       = tv[i].act;
      en        = tv[i].en;
      wr        = {4{tv[i].wr}};
      reg_stall = tv[i].rs;
      for (int r = 0; r < 4; r++) begin
        addr[r*32 +: 32]  = tv[i].addr | (32'(r) << 12);
        wdata[r*64 +: 64] = {32'hD0 + 32'(r), tv[i].addr};
      end
      #1;
      exp_addr  = (tv[i].own >= 0) ? (tv[i].addr | (32'(tv[i].own) << 12)) : 32'h0;
      exp_wdata = (tv[i].own >= 0) ? {32'hD0 + 32'(tv[i].own), tv[i].addr} : 64'h0;
      exp_wr    = (tv[i].own >= 0) ? tv[i].wr : 1'b0;
      chk($sformatf("row%0d stall", i),  stall,     tv[i].e_stall);
      chk($sformatf("row%0d rvalid", i), rvalid,    tv[i].e_rv);
      chk($sformatf("row%0d reg_en", i), reg_en,    tv[i].e_en);
      chk($sformatf("row%0d reg_wr", i), reg_wr,    exp_wr);
      chk($sformatf("row%0d addr", i),   reg_addr,  exp_addr);
      chk($sformatf("row%0d wdata", i),  reg_wdata, exp_wdata);
      chk($sformatf("row%0d err", i),    err,       tv[i].e_err);
      if (tv[i].e_rv != 4'h0)
        chk($sformatf("row%0d rdata", i), rdata, {32'hCAFE0000, prev_addr});
      prev_addr = exp_addr;
    end
    rst = 1'b0;

    // High-priority class: 3 must take over from 0 although the pointer favours 1
    @(negedge clk); h_act = 4'b0000; #1 chk("hp reset stall", h_stall, 4'hF);
    @(negedge clk); h_act = 4'b0001; #1 chk("hp req0 idle", h_stall, 4'hF);
    @(negedge clk); h_act = 4'b1011; #1 chk("hp own0", h_stall, 4'hE);
    @(negedge clk); h_act = 4'b1010; #1 chk("hp own0 release", h_stall, 4'hE);
    @(negedge clk);                  #1 chk("hp hiprio wins", h_stall, 4'h7);
    @(negedge clk); h_act = 4'b0010; #1 chk("hp own3 release", h_stall, 4'h7);
    @(negedge clk);                  #1 chk("hp rr to 1", h_stall, 4'hD);
    chk("hp no access", h_reg_en, 1'b0);
    chk("hp no err", h_err, 4'h0);
    h_act = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
